// File: rtl/veda_fetch.sv
// veda_fetch: instruction-fetch stage in front of the unified memory.
// It keeps one fetch request in flight against a memory with a one-cycle
// read latency. Responses go to the decode output register, or to a 1-entry
// skid buffer when decode is stalled. It also handles branch redirects, a halt
// opcode, and a count of instructions accepted by decode.
module veda_fetch #(
  parameter int                  ADDR_W      = 9,
  parameter int                  DATA_W      = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC    = {ADDR_W{1'b0}},
  parameter logic [5:0]          HALT_OPCODE = 6'b111111,
  parameter int                  CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_w_en,
  output logic              mem_mode,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              instr_ready,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Opcode field of an instruction word equals the halt opcode.
  function automatic logic is_halt_word(input logic [DATA_W-1:0] word);
    return (word[DATA_W-1:DATA_W-6] == HALT_OPCODE);
  endfunction

  state_t              state_r;
  logic [ADDR_W-1:0]   pc_r;
  logic                req_valid_r;
  logic [ADDR_W-1:0]   req_pc_r;
  logic                skid_valid_r;
  logic [DATA_W-1:0]   skid_instr_r;
  logic [ADDR_W-1:0]   skid_pc_r;
  logic                instr_valid_r;
  logic [DATA_W-1:0]   instr_r;
  logic [ADDR_W-1:0]   instr_pc_r;
  logic                halted_r;
  logic [CNT_W-1:0]    fetch_count_r;

  logic                accept_s;
  logic                out_free_s;
  logic                halt_hit_s;
  logic                issue_s;

  // The memory port is always driven in instruction-read mode from the PC.
  assign mem_w_en    = 1'b0;
  assign mem_mode    = 1'b1;
  assign mem_addr    = pc_r;

  assign instr_valid = instr_valid_r;
  assign instr       = instr_r;
  assign instr_pc    = instr_pc_r;
  assign halted      = halted_r;
  assign fetch_count = fetch_count_r;

  // Handshake, halt-detect and issue decisions for the current cycle.
  always_comb begin
    accept_s   = instr_valid_r & instr_ready;
    out_free_s = ~instr_valid_r | instr_ready;
    if (accept_s) begin
      halt_hit_s = is_halt_word(instr_r);
    end else begin
      halt_hit_s = 1'b0;
    end
    // Do not issue when the skid entry is occupied, or when the response
    // already in flight would itself have to park in the skid buffer.
    if (state_r == ST_RUN) begin
      issue_s = ~skid_valid_r & ~(req_valid_r & instr_valid_r & ~instr_ready);
    end else begin
      issue_s = 1'b0;
    end
  end

  // Fetch state machine: PC, in-flight request, skid buffer, output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_RUN;
      pc_r          <= RESET_PC;
      req_valid_r   <= 1'b0;
      req_pc_r      <= {ADDR_W{1'b0}};
      skid_valid_r  <= 1'b0;
      skid_instr_r  <= {DATA_W{1'b0}};
      skid_pc_r     <= {ADDR_W{1'b0}};
      instr_valid_r <= 1'b0;
      instr_r       <= {DATA_W{1'b0}};
      instr_pc_r    <= {ADDR_W{1'b0}};
      halted_r      <= 1'b0;
      fetch_count_r <= {CNT_W{1'b0}};
    end else begin
      // An instruction taken by decode counts even in a redirect cycle.
      if (accept_s) begin
        fetch_count_r <= fetch_count_r + CNT_ONE;
      end

      if (branch_valid) begin
        // Redirect squashes everything in flight and leaves HALTED.
        state_r       <= ST_RUN;
        pc_r          <= branch_target;
        req_valid_r   <= 1'b0;
        skid_valid_r  <= 1'b0;
        instr_valid_r <= 1'b0;
        halted_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_RUN: begin
            if (halt_hit_s) begin
              // The halt word itself was delivered this cycle. Prefetched
              // words behind it are dropped, and the PC stays put.
              state_r       <= ST_HALTED;
              halted_r      <= 1'b1;
              req_valid_r   <= 1'b0;
              skid_valid_r  <= 1'b0;
              instr_valid_r <= 1'b0;
            end else begin
              if (issue_s) begin
                req_valid_r <= 1'b1;
                req_pc_r    <= pc_r;
                pc_r        <= pc_r + PC_ONE;
              end else begin
                req_valid_r <= 1'b0;
              end

              if (out_free_s) begin
                if (skid_valid_r) begin
                  // The older skid entry goes out first. A response arriving
                  // now takes its place in the skid buffer.
                  instr_r       <= skid_instr_r;
                  instr_pc_r    <= skid_pc_r;
                  instr_valid_r <= 1'b1;
                  if (req_valid_r) begin
                    skid_instr_r <= mem_rdata;
                    skid_pc_r    <= req_pc_r;
                    skid_valid_r <= 1'b1;
                  end else begin
                    skid_valid_r <= 1'b0;
                  end
                end else if (req_valid_r) begin
                  instr_r       <= mem_rdata;
                  instr_pc_r    <= req_pc_r;
                  instr_valid_r <= 1'b1;
                end else begin
                  instr_valid_r <= 1'b0;
                end
              end else begin
                // Output is stalled: hold it and park any response.
                if (req_valid_r) begin
                  skid_instr_r <= mem_rdata;
                  skid_pc_r    <= req_pc_r;
                  skid_valid_r <= 1'b1;
                end else begin
                  skid_valid_r <= skid_valid_r;
                end
              end
            end
          end
          ST_HALTED: begin
            // Only reset or a redirect leaves this state.
            req_valid_r   <= 1'b0;
            skid_valid_r  <= 1'b0;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b1;
          end
          default: begin
            state_r       <= ST_RUN;
            req_valid_r   <= 1'b0;
            skid_valid_r  <= 1'b0;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_veda_fetch.sv
// tb_veda_fetch: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a queue-based model.
module tb_veda_fetch;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_w_en;
  logic          mem_mode;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic          branch_valid;
  logic [AW-1:0] branch_target;
  logic          instr_ready;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          halted;
  logic [CW-1:0] fetch_count;

  always #5 clk = ~clk;

  // Synchronous-read memory: data for the address seen at an edge is
  // available during the following cycle.
  logic [DW-1:0] mem [0:511];
  always @(posedge clk) mem_rdata <= mem[mem_addr];

  veda_fetch dut (
    .clk(clk), .rst(rst),
    .mem_w_en(mem_w_en), .mem_mode(mem_mode), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .instr_ready(instr_ready), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc),
    .halted(halted), .fetch_count(fetch_count)
  );

  // Behavioural model. The queue holds delivered-but-unaccepted words in
  // order; its front is what decode sees.
  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          q[$];
  logic [AW-1:0] m_pc;
  logic [AW-1:0] m_req_pc;
  bit            m_req;
  bit            m_halted;
  logic [CW-1:0] m_count;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step(input bit r, input bit b, input logic [AW-1:0] t, input bit rdy);
    bit   acc;
    bit   hit;
    bit   iss;
    int   n;
    ent_t resp;
    acc = (q.size() > 0) && rdy;
    if (r) begin
      m_pc = '0; m_req = 0; m_req_pc = '0; q.delete(); m_halted = 0; m_count = '0;
      return;
    end
    if (acc) m_count = m_count + 16'd1;
    if (b) begin
      m_pc = t; m_req = 0; q.delete(); m_halted = 0;
      return;
    end
    if (m_halted) return;
    hit = acc && (q[0].data[31:26] == 6'h3F);
    if (hit) begin
      m_halted = 1; m_req = 0; q.delete();
      return;
    end
    n   = q.size();
    iss = (n < 2) && !(m_req && (n == 1) && !rdy);
    if (acc) void'(q.pop_front());
    if (m_req) begin
      resp.pc   = m_req_pc;
      resp.data = mem[m_req_pc];
      q.push_back(resp);
    end
    m_req = iss;
    if (iss) begin
      m_req_pc = m_pc;
      m_pc     = m_pc + 9'd1;
    end
  endtask

  task automatic compare_model();
    chk("mem_w_en", {31'd0, mem_w_en}, 32'd0);
    chk("mem_mode", {31'd0, mem_mode}, 32'd1);
    chk("mem_addr", {23'd0, mem_addr}, {23'd0, m_pc});
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, (q.size() > 0)});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    chk("fetch_count", {16'd0, fetch_count}, {16'd0, m_count});
    if (q.size() > 0) begin
      chk("instr", instr, q[0].data);
      chk("instr_pc", {23'd0, instr_pc}, {23'd0, q[0].pc});
    end
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic step(input bit r, input bit b, input logic [AW-1:0] t, input bit rdy);
    rst = r; branch_valid = b; branch_target = t; instr_ready = rdy;
    model_step(r, b, t, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  task automatic lit_instr(input string name, input logic [AW-1:0] pc);
    chk({name, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({name, "_pc"}, {23'd0, instr_pc}, {23'd0, pc});
  endtask

  initial begin
    logic [31:0] w;
    logic [AW-1:0] tgt;
    rst = 1'b1; branch_valid = 1'b0; branch_target = '0; instr_ready = 1'b0;
    for (int a = 0; a < 512; a++) mem[a] = 32'h0000_1000 + a;
    @(negedge clk);

    // Straight-line fetch.
    step(1, 0, '0, 1);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", {23'd0, instr_pc}, 32'd0);
    chk("rst_count", {16'd0, fetch_count}, 32'd0);
    chk("rst_addr", {23'd0, mem_addr}, 32'd0);
    step(0, 0, '0, 1);
    chk("c1_valid", {31'd0, instr_valid}, 32'd0);
    for (int k = 0; k < 8; k++) begin
      step(0, 0, '0, 1);
      lit_instr("line", k[AW-1:0]);
      chk("line_data", instr, 32'h0000_1000 + k);
    end
    step(0, 0, '0, 1);
    chk("line_count8", {16'd0, fetch_count}, 32'd8);

    // Backpressure while instr_pc=3.
    step(1, 0, '0, 1);
    for (int k = 0; k < 5; k++) step(0, 0, '0, 1);
    lit_instr("bp_pre", 9'd3);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, '0, 0);
      lit_instr("bp_hold", 9'd3);
    end
    step(0, 0, '0, 1);
    lit_instr("bp_rel", 9'd4);
    for (int k = 0; k < 6; k++) step(0, 0, '0, 1);

    // Branch while instr_pc=5.
    step(1, 0, '0, 1);
    for (int k = 0; k < 7; k++) step(0, 0, '0, 1);
    lit_instr("br_pre", 9'd5);
    step(0, 1, 9'h100, 1);
    chk("br_count", {16'd0, fetch_count}, 32'd6);
    chk("br_sq1", {31'd0, instr_valid}, 32'd0);
    step(0, 0, '0, 1);
    chk("br_sq2", {31'd0, instr_valid}, 32'd0);
    step(0, 0, '0, 1);
    lit_instr("br_tgt", 9'h100);
    step(0, 0, '0, 1);
    lit_instr("br_tgt1", 9'h101);

    // Wrap-around.
    step(0, 1, 9'h1FE, 1);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    lit_instr("wrap0", 9'h1FE);
    step(0, 0, '0, 1);
    lit_instr("wrap1", 9'h1FF);
    step(0, 0, '0, 1);
    lit_instr("wrap2", 9'h000);
    step(0, 0, '0, 1);
    lit_instr("wrap3", 9'h001);

    // Halt at address 4.
    step(1, 0, '0, 1);
    mem[4] = 32'hFC00_0000;
    for (int k = 0; k < 6; k++) step(0, 0, '0, 1);
    lit_instr("halt_word", 9'd4);
    chk("halt_data", instr, 32'hFC00_0000);
    step(0, 0, '0, 1);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_count", {16'd0, fetch_count}, 32'd5);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, '0, 1);
      chk("halt_idle", {31'd0, instr_valid}, 32'd0);
    end
    step(0, 1, 9'd0, 1);
    chk("halt_exit", {31'd0, halted}, 32'd0);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    lit_instr("halt_restart", 9'd0);

    // Reset mid-operation with the skid buffer occupied.
    step(1, 0, '0, 1);
    mem[4] = 32'h0000_1004;
    for (int k = 0; k < 4; k++) step(0, 0, '0, 1);
    step(0, 0, '0, 0);
    step(0, 0, '0, 0);
    step(1, 0, '0, 0);
    chk("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_rst_count", {16'd0, fetch_count}, 32'd0);
    chk("mid_rst_addr", {23'd0, mem_addr}, 32'd0);
    step(0, 0, '0, 1);
    step(0, 0, '0, 1);
    lit_instr("mid_rst_resume", 9'd0);

    // Randomized traffic: new memory image loaded while nothing is in flight.
    step(1, 0, '0, 1);
    for (int a = 0; a < 512; a++) begin
      w = $urandom;
      if ($urandom_range(0, 39) == 0) w[31:26] = 6'h3F;
      else if (w[31:26] == 6'h3F) w[31] = 1'b0;
      mem[a] = w;
    end
    for (int c = 0; c < 4000; c++) begin
      tgt = $urandom_range(0, 511);
      if ($urandom_range(0, 3) == 0) tgt = 9'h1F8 + $urandom_range(0, 7);
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 24) == 0),
           tgt,
           ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/veda_fetch.md
Name: veda_fetch

Overview:
Instruction-fetch stage that sits directly upstream of the unified instruction/data memory. It drives that memory's port in instruction mode (w_en=0, mode=1) from a 9-bit program counter and captures the returned 32-bit words. It presents them to decode through a valid/ready handshake and absorbs the one-cycle memory latency with a 1-entry skid buffer. It also handles branch redirects, a halt opcode and an accepted-instruction counter.

Parameters:
ADDR_W, 9, program-counter and memory address width
DATA_W, 32, instruction width
RESET_PC, 0, PC value after reset
HALT_OPCODE, 6'b111111, value of instr[31:26] that halts fetch
CNT_W, 16, width of fetch_count

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
mem_w_en  output  1  memory write enable, constant 0
mem_mode  output  1  memory mode select, constant 1 (instruction space)
mem_addr  output  ADDR_W  fetch address, combinational from the PC register
mem_rdata  input  DATA_W  memory read data, valid one cycle after mem_addr is sampled
branch_valid  input  1  redirect request from execute
branch_target  input  ADDR_W  redirect address
instr_ready  input  1  decode can accept instr this cycle
instr_valid  output  1  instr/instr_pc hold a valid instruction
instr  output  DATA_W  fetched instruction
instr_pc  output  ADDR_W  address of instr
halted  output  1  fetch stopped on HALT_OPCODE
fetch_count  output  CNT_W  number of instructions accepted by decode

Behaviour:
- Reset (rst=1 at a clock edge): pc=RESET_PC, req_valid=0, skid_valid=0, instr_valid=0, instr=0, instr_pc=0, halted=0, fetch_count=0, state=RUN. rst has priority over all other inputs.
- States: RUN and HALTED.
- Issue rule (RUN only): a fetch is issued in a cycle when skid_valid=0 and NOT (req_valid=1 and instr_valid=1 and instr_ready=0).
  - On issue: req_valid<=1, req_pc<=pc, pc<=pc+1 modulo 2^ADDR_W (511 wraps to 0).
  - Otherwise: req_valid<=0 and pc holds.
- Latency: mem_addr=pc during cycle t. mem_rdata for that address is sampled at the end of cycle t+1. With no stall, the instruction is on instr at cycle t+2. Steady state is 1 instruction per cycle.
- Response routing when req_valid=1:
  - If the output register is empty or consumed this cycle (instr_valid=0 or instr_ready=1), the response is loaded into the output register: instr<=mem_rdata, instr_pc<=req_pc, instr_valid<=1.
  - Otherwise the response is loaded into the skid buffer.
- When the output is consumed and skid_valid=1, the skid entry moves to the output first, in order. A response arriving in the same cycle goes into the skid buffer.
- When the output is consumed and nothing is pending, instr_valid<=0.
- Handshake: instr, instr_pc and instr_valid stay stable while instr_valid=1 and instr_ready=0. Instructions are never dropped or duplicated except by flush.
- fetch_count increments on every cycle where instr_valid and instr_ready are both 1. It wraps at 2^CNT_W.
- Redirect: branch_valid=1 takes priority over issue, routing and halt.
  - Next edge: pc<=branch_target, req_valid<=0, skid_valid<=0, instr_valid<=0, state<=RUN, halted<=0.
  - No fetch is issued in the redirect cycle. The instruction at branch_target appears on instr 3 cycles after the branch_valid cycle.
  - An instruction accepted in the branch_valid cycle still counts in fetch_count.
- Halt: when the accepted instruction has instr[31:26]==HALT_OPCODE (and branch_valid=0):
  - state<=HALTED, halted<=1.
  - req_valid, skid_valid and instr_valid are cleared; prefetched words are dropped.
  - The halt instruction itself is delivered and counted.
- In HALTED: no issue, mem_addr holds the last pc, outputs stay invalid. Only rst or branch_valid leaves HALTED.
- mem_w_en=0 and mem_mode=1 in every cycle, including during reset.

Test Plan:
- Straight-line fetch: memory holds word k at address k (k=0..7), instr_ready=1, release rst at cycle 0 -> instr_valid rises at cycle 2; instr/instr_pc equal 0,1,2,... one per cycle; fetch_count=8 after 8 accepts.
- Backpressure: instr_ready=0 for 4 cycles while instr_pc=3 -> instr stays 3, no more than one word held in the skid buffer; after release, sequence 4,5,6 continues with no gaps or duplicates.
- Branch: branch_valid=1 with branch_target=9'h100 while instr_pc=5 -> in-flight 6 and 7 are squashed, next valid instr_pc=0x100 exactly 3 cycles later, then 0x101.
- Wrap-around: branch_target=9'h1FE with ready held high -> instr_pc sequence 0x1FE, 0x1FF, 0x000, 0x001.
- Halt: place 32'hFC000000 at address 4 -> instr_pc=4 is delivered; halted=1 next cycle; instr_valid stays 0 thereafter; fetch_count=5; a later branch_valid to address 0 restarts fetch with halted=0.
- Reset mid-operation: assert rst while skid_valid=1 and instr_valid=1 -> next cycle instr_valid=0, fetch_count=0, mem_addr=RESET_PC; fetch of address 0 resumes after rst falls.
